pu_ctrl_host: RTL and testbench

- Host-side controller that drives the control side of the processing unit's control interface: doorbell, external-input interrupt request and wakeup.
- Queues host doorbell rings, latches and masks external interrupt lines, and wakes the PU from sleep when work is pending.
- Consumes the PU's acknowledges and monitor signals, and runs a stall watchdog on the monitored PC.
- Sits between the host/system interrupt fabric and the PU.

---
 rtl/pu_ctrl_host.sv | 129 ++++++++++++
 tb/tb_pu_ctrl_host.sv | 242 ++++++++++++++++++++++++
 2 files changed

// File: rtl/pu_ctrl_host.sv
// Host-side control for the PU: doorbell queue, masked edge-triggered external
// interrupts, sleep/wake handshake, PC stall watchdog and an other_ack counter.
module pu_ctrl_host #(
    parameter int N_EXT       = 8,
    parameter int MAX_PEND    = 15,
    parameter int ADDR_W      = 32,
    parameter int STALL_LIMIT = 1024,
    parameter int CNT_W       = 16,
    localparam int CW         = (N_EXT > 1) ? $clog2(N_EXT) : 1
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              host_ring,
    input  logic              host_wake,
    input  logic [N_EXT-1:0]  ext_irq,
    input  logic [N_EXT-1:0]  ext_mask,
    input  logic              stall_clr,
    input  logic              sleep,
    input  logic              doorbell_ack,
    input  logic              ext_input_ack,
    input  logic              other_ack,
    input  logic [ADDR_W-1:0] mon_pc,
    input  logic              mon_hold_dc,
    output logic              doorbell,
    output logic              ext_input,
    output logic [CW-1:0]     ext_cause,
    output logic              wakeup,
    output logic              ring_ovf,
    output logic              stall,
    output logic [CNT_W-1:0]  other_ack_cnt
);
    localparam int PW = $clog2(MAX_PEND + 1);
    localparam int SW = (STALL_LIMIT > 0) ? $clog2(STALL_LIMIT + 1) : 1;

    typedef enum logic [1:0] {ST_RUN, ST_SLEEP, ST_WAKE} state_t;

    state_t            state, state_n;
    logic [PW-1:0]     pend_cnt, pend_cnt_n;
    logic              ovf_n, ack_take, work;
    logic [N_EXT-1:0]  irq_prev, pend, pend_n, clr, act_n;
    logic [CW-1:0]     cause_n;
    logic [ADDR_W-1:0] pc_prev;
    logic [SW-1:0]     wd_cnt, wd_cnt_n;
    logic              stall_set;

    assign ack_take = doorbell_ack && (pend_cnt != '0);
    assign work     = doorbell | ext_input | host_wake;

    // A ring and a valid ack in the same cycle cancel out.
    always_comb begin
        pend_cnt_n = pend_cnt;
        ovf_n      = 1'b0;
        if (host_ring && !ack_take) begin
            if (pend_cnt == PW'(MAX_PEND)) ovf_n = 1'b1;
            else                           pend_cnt_n = pend_cnt + PW'(1);
        end else if (!host_ring && ack_take) begin
            pend_cnt_n = pend_cnt - PW'(1);
        end
    end

    // The ack clears the line currently presented; a new edge on it wins.
    always_comb begin
        clr     = '0;
        cause_n = '0;
        for (int i = 0; i < N_EXT; i++)
            clr[i] = ext_input && ext_input_ack && (ext_cause == CW'(i));
        pend_n = (pend & ~clr) | (ext_irq & ~irq_prev);
        act_n  = pend_n & ext_mask;
        for (int i = N_EXT - 1; i >= 0; i--)
            if (act_n[i]) cause_n = CW'(i);
    end

    always_comb begin
        state_n = state;
        case (state)
            ST_RUN:   if (sleep) state_n = work ? ST_WAKE : ST_SLEEP;
            ST_SLEEP: if (work) state_n = ST_WAKE;
                      else if (!sleep) state_n = ST_RUN;
            ST_WAKE:  if (!sleep) state_n = ST_RUN;
            default:  state_n = ST_RUN;
        endcase
    end

    // Counter only advances while the PU runs with a frozen PC and no D-cache hold.
    always_comb begin
        wd_cnt_n = wd_cnt;
        if (STALL_LIMIT == 0 || state != ST_RUN || mon_pc != pc_prev || mon_hold_dc)
            wd_cnt_n = '0;
        else if (wd_cnt != SW'(STALL_LIMIT))
            wd_cnt_n = wd_cnt + SW'(1);
        stall_set = (STALL_LIMIT != 0) && (wd_cnt_n == SW'(STALL_LIMIT));
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) state <= ST_RUN;
        else       state <= state_n;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pend_cnt      <= '0;
            doorbell      <= 1'b0;
            ring_ovf      <= 1'b0;
            irq_prev      <= '0;
            pend          <= '0;
            ext_input     <= 1'b0;
            ext_cause     <= '0;
            wakeup        <= 1'b0;
            pc_prev       <= '0;
            wd_cnt        <= '0;
            stall         <= 1'b0;
            other_ack_cnt <= '0;
        end else begin
            pend_cnt  <= pend_cnt_n;
            doorbell  <= (pend_cnt_n != '0);
            ring_ovf  <= ovf_n;
            irq_prev  <= ext_irq;
            pend      <= pend_n;
            ext_input <= |act_n;
            ext_cause <= cause_n;
            wakeup    <= (state_n == ST_WAKE);
            pc_prev   <= mon_pc;
            wd_cnt    <= (stall_clr && !stall_set) ? '0 : wd_cnt_n;
            stall     <= stall_set | (stall & ~stall_clr);
            if (other_ack && other_ack_cnt != '1)
                other_ack_cnt <= other_ack_cnt + CNT_W'(1);
        end
    end
endmodule

// File: tb/tb_pu_ctrl_host.sv
// Randomized and directed bench for pu_ctrl_host against a behavioural model.
module tb_pu_ctrl_host;
    localparam int N = 8, MP = 15, AW = 16, SL = 8, CNW = 4;
    localparam int M_RUN = 0, M_SLP = 1, M_WAKE = 2;

    logic           clk = 0, rst = 1;
    logic           host_ring = 0, host_wake = 0, stall_clr = 0, sleep = 0;
    logic           doorbell_ack = 0, ext_input_ack = 0, other_ack = 0, mon_hold_dc = 0;
    logic [N-1:0]   ext_irq = 0, ext_mask = 0;
    logic [AW-1:0]  mon_pc = 0;
    logic           doorbell, ext_input, wakeup, ring_ovf, stall;
    logic [2:0]     ext_cause;
    logic [CNW-1:0] other_ack_cnt;

    int checks = 0, errors = 0;
    bit cmp_en = 0, pc_freeze = 0;

    // model state
    int       m_pcnt, m_cause, m_mode, m_wd, m_oac;
    bit [N-1:0]  m_pend, m_prev;
    bit [AW-1:0] m_pc_prev;
    bit       m_db, m_ei, m_wk, m_ovf, m_stall, m_work;

    pu_ctrl_host #(.N_EXT(N), .MAX_PEND(MP), .ADDR_W(AW), .STALL_LIMIT(SL), .CNT_W(CNW)) dut (
        .clk(clk), .reset(rst), .host_ring(host_ring), .host_wake(host_wake),
        .ext_irq(ext_irq), .ext_mask(ext_mask), .stall_clr(stall_clr), .sleep(sleep),
        .doorbell_ack(doorbell_ack), .ext_input_ack(ext_input_ack), .other_ack(other_ack),
        .mon_pc(mon_pc), .mon_hold_dc(mon_hold_dc), .doorbell(doorbell),
        .ext_input(ext_input), .ext_cause(ext_cause), .wakeup(wakeup),
        .ring_ovf(ring_ovf), .stall(stall), .other_ack_cnt(other_ack_cnt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Behavioural model: advances once per clock from the inputs and its own outputs.
    initial begin
        forever begin
            @(posedge clk or posedge rst);
            if (rst) begin
                m_pcnt = 0; m_cause = 0; m_mode = M_RUN; m_wd = 0; m_oac = 0;
                m_pend = 0; m_prev = 0; m_pc_prev = 0;
                m_db = 0; m_ei = 0; m_wk = 0; m_ovf = 0; m_stall = 0;
            end else begin
                m_work = m_db | m_ei | host_wake;
                m_ovf = 0;
                if (host_ring && doorbell_ack && m_pcnt > 0) m_pcnt = m_pcnt;
                else if (host_ring) begin
                    if (m_pcnt == MP) m_ovf = 1; else m_pcnt++;
                end else if (doorbell_ack && m_pcnt > 0) m_pcnt--;
                m_db = (m_pcnt != 0);

                if (ext_input_ack && m_ei) m_pend[m_cause] = 0;
                m_pend = m_pend | (ext_irq & ~m_prev);
                m_prev = ext_irq;
                m_ei = 0; m_cause = 0;
                for (int i = 0; i < N; i++)
                    if (!m_ei && m_pend[i] && ext_mask[i]) begin m_ei = 1; m_cause = i; end

                if (m_mode == M_RUN && mon_pc == m_pc_prev && !mon_hold_dc)
                    m_wd = (m_wd < SL) ? m_wd + 1 : SL;
                else m_wd = 0;
                if (m_wd == SL) m_stall = 1;
                else if (stall_clr) begin m_stall = 0; m_wd = 0; end
                m_pc_prev = mon_pc;

                if (other_ack && m_oac < (1 << CNW) - 1) m_oac++;

                case (m_mode)
                    M_RUN:  if (sleep) m_mode = m_work ? M_WAKE : M_SLP;
                    M_SLP:  if (m_work) m_mode = M_WAKE; else if (!sleep) m_mode = M_RUN;
                    default: if (!sleep) m_mode = M_RUN;
                endcase
                m_wk = (m_mode == M_WAKE);
            end
        end
    end

    always @(negedge clk) begin
        if (cmp_en) begin
            chk("doorbell", doorbell, m_db);
            chk("ext_input", ext_input, m_ei);
            chk("ext_cause", ext_cause, m_cause);
            chk("wakeup", wakeup, m_wk);
            chk("ring_ovf", ring_ovf, m_ovf);
            chk("stall", stall, m_stall);
            chk("other_ack_cnt", other_ack_cnt, m_oac);
        end
    end

    task automatic cyc();
        if (!pc_freeze) mon_pc = mon_pc + 1'b1;
        @(negedge clk);
    endtask

    task automatic idle();
        host_ring = 0; host_wake = 0; doorbell_ack = 0; ext_input_ack = 0;
        stall_clr = 0; other_ack = 0; mon_hold_dc = 0;
    endtask

    initial begin
        repeat (3) @(negedge clk);
        chk("rst_doorbell", doorbell, 0);
        chk("rst_ext_input", ext_input, 0);
        chk("rst_wakeup", wakeup, 0);
        chk("rst_stall", stall, 0);
        chk("rst_oac", other_ack_cnt, 0);
        rst = 0;
        cmp_en = 1;
        cyc();

        // doorbell counting
        host_ring = 1; repeat (3) cyc(); host_ring = 0;
        doorbell_ack = 1; cyc(); doorbell_ack = 0;
        chk("db_after_3r1a", doorbell, 1);
        chk("model_pcnt_2", m_pcnt, 2);
        doorbell_ack = 1; cyc();
        chk("db_one_left", doorbell, 1);
        cyc(); doorbell_ack = 0;
        chk("db_drained", doorbell, 0);
        doorbell_ack = 1; cyc(); doorbell_ack = 0;
        chk("db_extra_ack", doorbell, 0);
        chk("model_pcnt_0", m_pcnt, 0);

        // saturation
        host_ring = 1;
        for (int k = 1; k <= 17; k++) begin
            cyc();
            chk("ovf_ring", ring_ovf, (k >= 16) ? 1 : 0);
        end
        doorbell_ack = 1; cyc();
        chk("ovf_ring_ack", ring_ovf, 0);
        chk("model_pcnt_15", m_pcnt, 15);
        host_ring = 0; repeat (15) cyc(); doorbell_ack = 0;
        chk("db_sat_drained", doorbell, 0);

        // external interrupts
        ext_mask = 8'hFF; ext_irq = 8'h24; cyc();
        chk("ext_in_1", ext_input, 1);
        chk("ext_cause_2", ext_cause, 2);
        ext_input_ack = 1; cyc(); ext_input_ack = 0;
        chk("ext_cause_5", ext_cause, 5);
        ext_input_ack = 1; cyc(); ext_input_ack = 0;
        chk("ext_in_0", ext_input, 0);
        ext_irq = 0; cyc();
        ext_mask = 8'hF7; ext_irq = 8'h08; cyc();
        chk("ext_masked_a", ext_input, 0);
        cyc();
        chk("ext_masked_b", ext_input, 0);
        ext_mask = 8'hFF; cyc();
        chk("ext_unmasked", ext_input, 1);
        chk("ext_cause_3", ext_cause, 3);
        ext_input_ack = 1; cyc(); ext_input_ack = 0; ext_irq = 0;
        chk("ext_cleared", ext_input, 0);

        // sleep / wake
        sleep = 1; cyc();
        chk("slp_wakeup_0", wakeup, 0);
        chk("model_mode_slp", m_mode, M_SLP);
        repeat (2) cyc();
        chk("slp_still_0", wakeup, 0);
        host_ring = 1; cyc(); host_ring = 0;
        chk("slp_db_up", doorbell, 1);
        chk("slp_wk_not_yet", wakeup, 0);
        cyc();
        chk("wk_up", wakeup, 1);
        repeat (3) cyc();
        chk("wk_held", wakeup, 1);
        sleep = 0; cyc();
        chk("wk_down", wakeup, 0);
        doorbell_ack = 1; cyc(); doorbell_ack = 0;

        // asynchronous reset while in WAKE with 4 pending
        host_ring = 1; repeat (4) cyc(); host_ring = 0;
        sleep = 1; cyc();
        chk("pre_rst_wake", wakeup, 1);
        chk("model_pcnt_4", m_pcnt, 4);
        @(posedge clk); #2 rst = 1; #1;
        chk("arst_doorbell", doorbell, 0);
        chk("arst_wakeup", wakeup, 0);
        chk("arst_ext", ext_input, 0);
        chk("arst_cause", ext_cause, 0);
        chk("arst_ovf", ring_ovf, 0);
        chk("arst_stall", stall, 0);
        sleep = 0;
        @(negedge clk); rst = 0;
        cyc();
        chk("post_rst_db", doorbell, 0);
        host_ring = 1; cyc(); host_ring = 0;
        doorbell_ack = 1; cyc(); doorbell_ack = 0;
        chk("post_rst_count", doorbell, 0);

        // watchdog
        mon_pc = mon_pc ^ 16'h8000; pc_freeze = 1; cyc();
        repeat (7) cyc();
        chk("wd_7", stall, 0);
        cyc();
        chk("wd_8", stall, 1);
        pc_freeze = 0; stall_clr = 1; cyc(); stall_clr = 0;
        chk("wd_clr", stall, 0);
        pc_freeze = 1; repeat (4) cyc();
        mon_hold_dc = 1; cyc(); mon_hold_dc = 0;
        repeat (7) cyc();
        chk("wd_hold_7", stall, 0);
        cyc();
        chk("wd_hold_8", stall, 1);
        pc_freeze = 0; stall_clr = 1; cyc(); stall_clr = 0;
        chk("wd_clr2", stall, 0);

        // other_ack saturation
        other_ack = 1; repeat (20) cyc(); other_ack = 0;
        chk("oac_sat", other_ack_cnt, 15);

        // randomized traffic
        for (int n = 0; n < 3000; n++) begin
            host_ring     = ($urandom_range(0, 2) == 0);
            doorbell_ack  = ($urandom_range(0, 2) == 0);
            ext_input_ack = ($urandom_range(0, 2) == 0);
            host_wake     = ($urandom_range(0, 19) == 0);
            mon_hold_dc   = ($urandom_range(0, 15) == 0);
            stall_clr     = ($urandom_range(0, 23) == 0);
            other_ack     = ($urandom_range(0, 3) == 0);
            if ($urandom_range(0, 3) == 0) ext_irq = N'($urandom);
            if ($urandom_range(0, 15) == 0) ext_mask = N'($urandom);
            if ($urandom_range(0, 9) == 0) sleep = ~sleep;
            if ($urandom_range(0, 19) == 0) pc_freeze = ~pc_freeze;
            cyc();
        end
        idle();
        cyc();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
